fifo_store_ptr: RTL and testbench

- Data store plus write and read pointer generators for a circular FIFO.
- Holds MAX_DATA words in a memory array and owns the write and read addresses.
- The addresses advance on enable and wrap to 0 after MAX_DATA-1.
- Sits beneath the FIFO control layer. That layer owns occupancy counting, full/empty, and the skip decisions (overwrite-oldest, read-while-empty); this block only executes them.

---
 rtl/fifo_store_ptr.sv | 51 +++++
 tb/tb_fifo_store_ptr.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_store_ptr.sv
// Circular FIFO data store with write/read address generators; pointer update 1 cycle, rdata combinational.
// No backpressure: wen/ren/wskip/rskip are executed unconditionally, full/empty is the caller's job.
module fifo_store_ptr #(
    parameter int MAX_DATA = 16,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic              ren,
    input  logic              wskip,
    input  logic              rskip,
    input  logic [DATA_W-1:0] wdata,
    output logic [3:0]        waddr,
    output logic [3:0]        raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [3:0] LAST_ADDR = 4'(MAX_DATA - 1);

    logic [DATA_W-1:0] mem [0:MAX_DATA-1];
    logic              wstep;
    logic              rstep;
    logic [3:0]        waddr_nxt;
    logic [3:0]        raddr_nxt;

    // A skip and a real access in the same cycle still move the pointer only once.
    assign wstep = wen | wskip;
    assign rstep = ren | rskip;

    assign waddr_nxt = (waddr == LAST_ADDR) ? 4'd0 : waddr + 4'd1;
    assign raddr_nxt = (raddr == LAST_ADDR) ? 4'd0 : raddr + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr <= 4'd0;
            raddr <= 4'd0;
        end else begin
            if (wstep) waddr <= waddr_nxt;
            if (rstep) raddr <= raddr_nxt;
        end
    end

    // Storage is deliberately left out of reset so contents survive a pointer reset.
    always_ff @(posedge clk) begin
        if (rst_n && wen) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: tb/tb_fifo_store_ptr.sv
// Scenario bench for fifo_store_ptr: default 16-deep instance plus a 5-deep wrap instance.
module tb_fifo_store_ptr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wen, ren, wskip, rskip;
    logic [7:0] wdata;
    logic [3:0] waddr, raddr;
    logic [7:0] rdata;

    logic       wen5, ren5, wskip5, rskip5;
    logic [7:0] wdata5;
    logic [3:0] waddr5, raddr5;
    logic [7:0] rdata5;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] m5 [0:4];

    always #5 clk = ~clk;

    fifo_store_ptr #(.MAX_DATA(16), .DATA_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .wskip(wskip), .rskip(rskip),
        .wdata(wdata), .waddr(waddr), .raddr(raddr), .rdata(rdata)
    );

    fifo_store_ptr #(.MAX_DATA(5), .DATA_W(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .wen(wen5), .ren(ren5), .wskip(wskip5), .rskip(rskip5),
        .wdata(wdata5), .waddr(waddr5), .raddr(raddr5), .rdata(rdata5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Mid-cycle asynchronous reset pulse; pointers must clear before any clock edge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk4("async_rst_waddr", waddr, 4'd0);
        chk4("async_rst_raddr", raddr, 4'd0);
        rst_n = 1'b1;
        exp_q.delete();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wen = 1'b1; ren = 1'b1; wdata = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk4("rst_hold_waddr", waddr, 4'd0);
            chk4("rst_hold_raddr", raddr, 4'd0);
            chk4("rst5_hold_waddr", waddr5, 4'd0);
        end
        #1 rst_n = 1'b1; ren = 1'b0;
        for (int i = 0; i < 5; i++) step();
        wen = 1'b0;
        chk4("pre_rst_waddr", waddr, 4'd5);
        pulse_reset();
        chk4("post_rst_waddr", waddr, 4'd0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1;
            wdata = 8'h10 + 8'(i);
            chk4("fill_waddr", waddr, 4'(i));
            exp_q.push_back(wdata);
            step();
        end
        wen = 1'b0;
        chk4("fill_wrap_waddr", waddr, 4'd0);
        for (int i = 0; i < 16; i++) begin
            ren = 1'b1;
            chk4("drain_raddr", raddr, 4'(i));
            chk8("drain_rdata", rdata, exp_q.pop_front());
            step();
        end
        ren = 1'b0;
        chk4("drain_wrap_raddr", raddr, 4'd0);
    endtask

    task automatic test_skips();
        for (int i = 0; i < 7; i++) begin
            wen = 1'b1;
            wdata = 8'hA0 + 8'(i);
            exp_q.push_back(wdata);
            step();
        end
        wen = 1'b0;
        chk4("pre_wskip_waddr", waddr, 4'd7);
        wskip = 1'b1;
        step();
        wskip = 1'b0;
        chk4("wskip_waddr", waddr, 4'd8);
        exp_q.push_back(8'h17);  // word 7 keeps its value from the fill pass
        for (int i = 0; i < 3; i++) begin
            ren = 1'b1;
            chk8("skip_rd_rdata", rdata, exp_q.pop_front());
            step();
        end
        ren = 1'b0;
        chk4("pre_rskip_raddr", raddr, 4'd3);
        chk8("pre_rskip_rdata", rdata, exp_q.pop_front());
        rskip = 1'b1;
        step();
        rskip = 1'b0;
        chk4("rskip_raddr", raddr, 4'd4);
        for (int i = 4; i < 8; i++) begin
            ren = 1'b1;
            chk4("skip_rd_raddr", raddr, 4'(i));
            chk8("skip_rd_rdata", rdata, exp_q.pop_front());
            step();
        end
        ren = 1'b0;
        chk4("skip_end_raddr", raddr, 4'd8);
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            wen = 1'b1;
            wdata = 8'h50 + 8'(i);
            exp_q.push_back(wdata);
            step();
        end
        wen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ren = 1'b1;
            chk8("sim_pre_rdata", rdata, exp_q.pop_front());
            step();
        end
        wen = 1'b1; ren = 1'b1; wdata = 8'h3C;
        chk8("same_addr_old_rdata", rdata, 8'hA2);
        step();
        wen = 1'b0; ren = 1'b0;
        chk4("sim_waddr", waddr, 4'd3);
        chk4("sim_raddr", raddr, 4'd3);
        pulse_reset();
        wen = 1'b1; wskip = 1'b1; wdata = 8'h77;
        step();
        wen = 1'b0; wskip = 1'b0;
        chk4("wen_wskip_waddr", waddr, 4'd1);
        chk8("wen_wskip_rdata", rdata, 8'h77);
        ren = 1'b1; rskip = 1'b1;
        step();
        rskip = 1'b0;
        chk4("ren_rskip_raddr", raddr, 4'd1);
        chk8("retained_rdata1", rdata, 8'h51);
        step();
        ren = 1'b0;
        chk4("sim_raddr2", raddr, 4'd2);
        chk8("same_addr_new_rdata", rdata, 8'h3C);
    endtask

    task automatic test_wrap5();
        int wexp, rexp;
        wexp = 0;
        for (int i = 0; i < 6; i++) begin
            wen5 = 1'b1;
            wdata5 = 8'h60 + 8'(i);
            m5[wexp] = wdata5;
            step();
            wexp = (wexp + 1) % 5;
            chk4("wrap5_waddr", waddr5, 4'(wexp));
            checks++;
            if (waddr5 >= 4'd5) begin
                errors++;
                $display("FAIL wrap5_range got %h expected below 5", waddr5);
            end
        end
        wen5 = 1'b0;
        rexp = 0;
        for (int i = 0; i < 6; i++) begin
            ren5 = 1'b1;
            chk8("wrap5_rdata", rdata5, m5[rexp]);
            step();
            rexp = (rexp + 1) % 5;
            chk4("wrap5_raddr", raddr5, 4'(rexp));
        end
        ren5 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wen = 1'b0; ren = 1'b0; wskip = 1'b0; rskip = 1'b0; wdata = 8'h00;
        wen5 = 1'b0; ren5 = 1'b0; wskip5 = 1'b0; rskip5 = 1'b0; wdata5 = 8'h00;
        #1;
        test_reset();
        test_fill_drain();
        test_skips();
        test_simultaneous();
        test_wrap5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
